// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, controller state type and digit-validity check
//   BCD_W            nibble width of one BCD digit
//   BCD_MAX          largest legal BCD digit value
//   bcd_ctrl_state_t serial adder controller states
//   is_bcd()         1 when a nibble holds a legal decimal digit
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam int BCD_MAX = 9;
  typedef enum logic [1:0] {IDLE, ADD, DONE} bcd_ctrl_state_t;
  function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
    return nibble <= BCD_W'(BCD_MAX);
  endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational one-digit decimal adder with carry
//   a_d, b_d  input digits
//   c         carry in
//   digit     decimal sum digit
//   c_out     decimal carry out
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a_d,
  input  logic [BCD_W-1:0] b_d,
  input  logic             c,
  output logic [BCD_W-1:0] digit,
  output logic             c_out
);
  logic [BCD_W:0] t;
  always_comb begin
    t = (BCD_W+1)'(a_d) + (BCD_W+1)'(b_d) + (BCD_W+1)'(c);
    c_out = t > (BCD_W+1)'(BCD_MAX);
    // adding 6 skips the six unused codes, wrapping the nibble back into 0..9
    digit = c_out ? t[BCD_W-1:0] + BCD_W'(6) : t[BCD_W-1:0];
  end
endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: multi-digit BCD adder reusing one digit stage, LSD first
//   clk, reset  clock and asynchronous active-high reset
//   start       request an addition (accepted only when idle)
//   a, b        packed BCD operands, digit 0 in the low nibble
//   carry_in    decimal carry into digit 0
//   busy        high while digits are being processed
//   done        one-cycle pulse when sum/carry_out/invalid are valid
//   sum         packed BCD result, held until the next accepted start
//   carry_out   decimal carry out of the top digit
//   invalid     some latched operand digit was not a legal BCD digit
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  input  logic                    carry_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] sum,
  output logic                    carry_out,
  output logic                    invalid
);
  localparam int W = BCD_W * DIGITS;
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  bcd_ctrl_state_t state;
  logic [W-1:0] op_a, op_b;
  logic [CW-1:0] cnt;
  logic carry, c_out, bad;
  logic [BCD_W-1:0] digit;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad |= !is_bcd(a[BCD_W*i +: BCD_W]) || !is_bcd(b[BCD_W*i +: BCD_W]);
  end
  bcd_digit_add u_digit (
    .a_d  (op_a[BCD_W*cnt +: BCD_W]),
    .b_d  (op_b[BCD_W*cnt +: BCD_W]),
    .c    (carry),
    .digit(digit),
    .c_out(c_out)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_a <= '0;
      op_b <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      carry_out <= 1'b0;
      invalid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_a <= a;
          op_b <= b;
          carry <= carry_in;
          cnt <= '0;
          sum <= '0;
          carry_out <= 1'b0;
          invalid <= bad;
          busy <= 1'b1;
          state <= ADD;
        end
        ADD: begin
          sum[BCD_W*cnt +: BCD_W] <= digit;
          carry <= c_out;
          if (cnt == CW'(DIGITS - 1)) begin
            carry_out <= c_out;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else cnt <= cnt + CW'(1);
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb_bcd_serial_adder_ctrl: scoreboard bench for the 4-digit serial BCD adder
module tb_bcd_serial_adder_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, carry_in = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic busy, done, carry_out, invalid;
  logic [15:0] sum;
  int checks = 0, errors = 0;
  typedef struct {
    logic [15:0] s;
    logic c;
    logic inv;
  } exp_t;
  exp_t q[$];
  bcd_serial_adder_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .carry_in(carry_in),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .invalid(invalid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int to_dec(input logic [15:0] x);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
    return r;
  endfunction
  function automatic logic [15:0] from_dec(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic logic non_bcd(input logic [15:0] x);
    logic r = 1'b0;
    for (int i = 0; i < 4; i++) r |= x[4*i +: 4] > 4'd9;
    return r;
  endfunction
  task automatic run_add(input logic [15:0] av, input logic [15:0] bv, input logic ci, input bit spam);
    exp_t e, g;
    int tot, n, bc;
    tot = to_dec(av) + to_dec(bv) + int'(ci);
    e.s = from_dec(tot % 10000);
    e.c = tot >= 10000;
    e.inv = non_bcd(av) || non_bcd(bv);
    q.push_back(e);
    @(negedge clk);
    a = av; b = bv; carry_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'h7777; b = 16'h2222; carry_in = 1'b1;
    n = 1; bc = 0;
    while (!done && n < 20) begin
      bc += int'(busy);
      start = spam && n == 1;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", n, 5);
    chk("busy_cycles", bc, 4);
    g = q.pop_front();
    if (!g.inv) chk("sum", sum, g.s);
    if (!g.inv) chk("carry_out", carry_out, g.c);
    chk("invalid", invalid, g.inv);
    chk("busy_at_done", busy, 0);
    start = spam;
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse_end", done, 0);
    chk("busy_after_done", busy, 0);
    if (spam) begin
      repeat (3) @(negedge clk);
      chk("sum_held", sum, g.s);
      chk("idle_held", {busy, done}, 0);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outputs", {sum, carry_out, done, busy, invalid}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {sum, carry_out, done, busy, invalid}, 0);
    run_add(16'h1234, 16'h5678, 1'b0, 0);
    run_add(16'h9999, 16'h0001, 1'b0, 0);
    run_add(16'h9999, 16'h9999, 1'b1, 0);
    run_add(16'h0005, 16'h0005, 1'b0, 1);
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_mid_add", busy, 1);
    #2 reset = 1'b1;
    #1 chk("async_reset", {sum, carry_out, done, busy, invalid}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, done, sum}, 0);
    run_add(16'h4321, 16'h1111, 1'b0, 0);
    run_add(16'h00A0, 16'h0001, 1'b0, 0);
    run_add(16'h0012, 16'h0034, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] ra, rb;
      ra = from_dec(int'($urandom_range(0, 9999)));
      rb = from_dec(int'($urandom_range(0, 9999)));
      run_add(ra, rb, 1'($urandom_range(0, 1)), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Multi-digit BCD adder that sequences a single one-digit BCD adder stage over `DIGITS` digits, least-significant digit first, one digit per clock. It latches both packed-BCD operands on a start request, ripples the decimal carry through a carry register, and presents the full sum with a one-cycle done pulse. It sits between the operand/result registers of the calculator datapath and the one-digit BCD adder. This trades `DIGITS` cycles of latency for a single adder instance.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand, ≥1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request an addition; honoured only in IDLE.
- `a` input 4*DIGITS: operand A, packed BCD, digit 0 in [3:0].
- `b` input 4*DIGITS: operand B, packed BCD.
- `carry_in` input 1: decimal carry into digit 0.
- `busy` output 1: high while in ADD.
- `done` output 1: one-cycle pulse, result valid.
- `sum` output 4*DIGITS: packed BCD result; held until next accepted start.
- `carry_out` output 1: decimal carry out of the top digit.
- `invalid` output 1: some latched operand digit was >9; held with the result.

## Operation
- The FSM has three states: IDLE, ADD, DONE. Encoding is local.
- **IDLE**
  - `start`=1: latch `a`, `b`, `carry_in` into the operand and carry registers.
  - Clear the digit counter `cnt` to 0 and clear the sum register.
  - Set `invalid` if any nibble of the latched `a` or `b` is >9.
  - Go to ADD.
- **ADD**
  - Each cycle, feed digit `cnt` of A and B plus the carry register to the digit stage.
  - Write the digit-stage sum into `sum[4*cnt +: 4]`. Write its carry back to the carry register.
  - If `cnt`==DIGITS-1: go to DONE and copy the carry register's new value to `carry_out`.
  - Otherwise increment `cnt`.
- **DONE**
  - `done`=1 for exactly this cycle, then go to IDLE unconditionally.
- `start` is ignored in ADD and DONE. It is not queued.
- **Digit-stage arithmetic**
  - t = a_d + b_d + c, computed 5 bits wide.
  - If t > 9: digit = (t + 6)[3:0], c_out = 1.
  - Otherwise: digit = t[3:0], c_out = 0.
- **Non-BCD digits**
  - Computation proceeds with the same rule. The result is undefined, but `invalid`=1 flags it.
  - No saturation and no abort.
- **Reset** (asynchronous, any state, including mid-ADD)
  - State goes to IDLE; `cnt`, operand and carry registers go to 0.
  - Outputs: `sum`=0, `carry_out`=0, `done`=0, `busy`=0, `invalid`=0.
  - A partial result is discarded.
- `sum`, `carry_out` and `invalid` change only on an accepted start (clear/load) and during ADD. They are stable from DONE until the next accepted start.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- Edges E1..E_DIGITS process digits 0..DIGITS-1. `busy`=1 from after E0 until after E_DIGITS.
- `done` is high in the cycle after E_DIGITS. Latency from start edge to done is DIGITS+1 edges.
- The earliest next accepted start is the edge after DONE, i.e. E_DIGITS+2. Throughput is one addition per DIGITS+2 cycles.
- All outputs are registered. No combinational path from inputs to outputs.
- Operand inputs need only be valid at E0.

## Structure
- Shared package `bcd_pkg`:
  - Constants `BCD_W`=4 and `BCD_MAX`=9.
  - State enum `bcd_ctrl_state_t` {IDLE, ADD, DONE}.
  - Function `is_bcd(nibble)`.
- One sub-module, `bcd_digit_add`:
  - Purely combinational one-digit stage with ports `a_d`[3:0], `b_d`[3:0], `c`, `digit`[3:0], `c_out`.
  - Implements the rule above. Instantiated exactly once.
- `cnt` width is $clog2(DIGITS), with a minimum of 1.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, carry_in=0, pulse start → `done` at E5, `sum`=0x6912, `carry_out`=0, `invalid`=0; `busy` high for 4 cycles.
- a=0x9999, b=0x0001, carry_in=0 → `sum`=0x0000, `carry_out`=1 (full carry ripple).
- a=0x9999, b=0x9999, carry_in=1 → `sum`=0x9999, `carry_out`=1.
- Start 0x0005+0x0005, then assert `start` again with other operands at E2 and at the DONE cycle → both ignored. `sum`=0x0010 and is held after done until the next accepted start.
- Start 0x4321+0x1111, assert `reset` asynchronously between E2 and E3 → all outputs 0 immediately, state IDLE. A fresh start then gives 0x5432 normally.
- a=0x00A0, b=0x0001 → `invalid`=1 at DONE, `done` still pulses at E5. The next start with valid BCD clears `invalid`.
